// File: rtl/simple_bus_initiator.sv
// Single-outstanding initiator for the sel/we/ready peripheral bus: takes one command,
// holds bus_sel until the peripheral strobes ready or the timer expires, then returns a response.
module simple_bus_initiator #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              bus_sel,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ready,
   input  logic [31:0]       bus_rdata
);

   localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_RESP
   } state_t;

   state_t              state_reg;
   logic [TIMER_W-1:0]  timer_reg;
   logic                bus_sel_reg;
   logic                bus_we_reg;
   logic [ADDR_W-1:0]   bus_addr_reg;
   logic [31:0]         bus_wdata_reg;
   logic                rsp_valid_reg;
   logic [31:0]         rsp_rdata_reg;
   logic                rsp_err_reg;

   // The only combinational output: accept is blocked while reset is asserted.
   assign cmd_ready = (state_reg == ST_IDLE) && !reset;

   assign bus_sel   = bus_sel_reg;
   assign bus_we    = bus_we_reg;
   assign bus_addr  = bus_addr_reg;
   assign bus_wdata = bus_wdata_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         timer_reg     <= '0;
         bus_sel_reg   <= 1'b0;
         bus_we_reg    <= 1'b0;
         bus_addr_reg  <= '0;
         bus_wdata_reg <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  bus_sel_reg   <= 1'b1;
                  bus_we_reg    <= cmd_we;
                  bus_addr_reg  <= cmd_addr;
                  bus_wdata_reg <= cmd_wdata;
                  timer_reg     <= '0;
                  state_reg     <= ST_BUS;
               end
            end
            ST_BUS: begin
               // Ready is checked before the timer so a strobe on the expiry cycle completes normally.
               if (bus_ready) begin
                  rsp_rdata_reg <= bus_we_reg ? 32'd0 : bus_rdata;
                  rsp_err_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  bus_sel_reg   <= 1'b0;
                  bus_we_reg    <= 1'b0;
                  state_reg     <= ST_RESP;
               end else if (timer_reg == TIMER_LAST) begin
                  rsp_rdata_reg <= 32'd0;
                  rsp_err_reg   <= 1'b1;
                  rsp_valid_reg <= 1'b1;
                  bus_sel_reg   <= 1'b0;
                  bus_we_reg    <= 1'b0;
                  state_reg     <= ST_RESP;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simple_bus_initiator.sv
// Directed and randomized transactions against simple_bus_initiator; expected responses
// are derived per transaction from when the bench's peripheral chooses to raise ready.
module tb_simple_bus_initiator;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_we = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [31:0]       cmd_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              bus_sel;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_wdata;
   logic              bus_ready = 1'b0;
   logic [31:0]       bus_rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   simple_bus_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ready_at: sel cycle (1-based) on which the peripheral strobes ready, 0 = never.
   // hold: cycles rsp_ready stays low. reset_at: sel cycle on which reset is raised, 0 = none.
   task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ready_at, input int hold,
                          input int reset_at);
      logic [31:0] slave_data;
      logic        exp_err;
      int          exp_sel;
      logic [31:0] exp_rdata;
      int          sel_cnt;
      bit          ended;

      slave_data = $urandom;
      exp_err    = (ready_at == 0) || (ready_at > TIMEOUT);
      exp_sel    = exp_err ? TIMEOUT : ready_at;
      exp_rdata  = (we || exp_err) ? 32'd0 : slave_data;

      @(negedge clk);
      chk({name, ".cmd_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
      chk({name, ".sel_idle"}, {31'd0, bus_sel}, 32'd0);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_we = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;

      sel_cnt = 0;
      ended = 1'b0;
      for (int g = 0; g < 300 && !ended; g++) begin
         @(negedge clk);
         if (!bus_sel) begin
            ended = 1'b1;
         end else begin
            sel_cnt++;
            if (sel_cnt == 1) begin
               chk({name, ".bus_we"}, {31'd0, bus_we}, {31'd0, we});
               chk({name, ".bus_addr"}, bus_addr, addr);
               chk({name, ".bus_wdata"}, bus_wdata, wdata);
               chk({name, ".cmd_ready_busy"}, {31'd0, cmd_ready}, 32'd0);
            end
            if (reset_at != 0 && sel_cnt == reset_at) begin
               reset = 1'b1;
               bus_ready = 1'b0;
               @(negedge clk);
               chk({name, ".rst_sel"}, {31'd0, bus_sel}, 32'd0);
               chk({name, ".rst_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
               chk({name, ".rst_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
               reset = 1'b0;
               @(negedge clk);
               chk({name, ".post_rst_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
               chk({name, ".post_rst_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
               chk({name, ".post_rst_sel"}, {31'd0, bus_sel}, 32'd0);
               $display("txn %s: reset injected at sel cycle %0d", name, reset_at);
               return;
            end
            bus_ready = (sel_cnt == ready_at);
            bus_rdata = (sel_cnt == ready_at) ? slave_data : $urandom;
         end
      end
      bus_ready = 1'b0;
      chk({name, ".bus_done"}, {31'd0, ended}, 32'd1);
      chk({name, ".sel_cycles"}, sel_cnt, exp_sel);
      chk({name, ".bus_we_clear"}, {31'd0, bus_we}, 32'd0);

      // Response phase: late ready strobes from the peripheral must be ignored.
      rsp_ready = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge clk);
         chk({name, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
         chk({name, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
         chk({name, ".rsp_rdata"}, rsp_rdata, exp_rdata);
         chk({name, ".rsp_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
         chk({name, ".rsp_sel"}, {31'd0, bus_sel}, 32'd0);
         bus_ready = $urandom;
         bus_rdata = $urandom;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({name, ".rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
      chk({name, ".idle_sel"}, {31'd0, bus_sel}, 32'd0);
      bus_ready = 1'b0;
      $display("txn %s: we=%0d addr=%h sel_cycles=%0d err=%0d rdata=%h", name, we, addr,
               sel_cnt, rsp_err, rsp_rdata);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset.cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("reset.bus_sel", {31'd0, bus_sel}, 32'd0);
      chk("reset.bus_we", {31'd0, bus_we}, 32'd0);
      chk("reset.bus_addr", bus_addr, 32'd0);
      chk("reset.bus_wdata", bus_wdata, 32'd0);
      chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset.rsp_rdata", rsp_rdata, 32'd0);
      chk("reset.rsp_err", {31'd0, rsp_err}, 32'd0);
      reset = 1'b0;

      run_txn("T1_write", 1'b1, 32'h8000_0010, 32'h0000_002A, 16, 0, 0);
      run_txn("T2_read", 1'b0, 32'h8000_0014, 32'h0, 1, 0, 0);
      run_txn("T3_timeout", 1'b0, 32'h8000_0020, 32'h0, 0, 3, 0);
      run_txn("T4_expiry", 1'b0, 32'h8000_0024, 32'h0, TIMEOUT, 0, 0);
      run_txn("T4b_past", 1'b0, 32'h8000_0028, 32'h0, TIMEOUT + 1, 0, 0);
      run_txn("T5_backpr", 1'b1, 32'h8000_0030, 32'hDEAD_BEEF, 3, 10, 0);
      run_txn("T5_b2b", 1'b0, 32'h8000_0034, 32'h0, 2, 0, 0);
      run_txn("T6_reset", 1'b0, 32'h8000_0040, 32'h0, 0, 0, 5);
      run_txn("T6_after", 1'b1, 32'h8000_0044, 32'h1234_5678, 4, 0, 0);

      for (int i = 0; i < 12; i++) begin
         logic        rwe;
         int          rat;
         rwe = $urandom;
         rat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT + 4);
         run_txn($sformatf("R%0d", i), rwe, $urandom, $urandom, rat, $urandom_range(0, 4), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
